// File: rtl/vreg_file_grouped_if.sv
// vreg_file_grouped_if: read ports, group-write handshake and status of vreg_file_grouped
//   master: drives readAddr*, cmd_*, dat_*; sees readVector*, v0, ready, busy, pulses
//   slave : the register file side
interface vreg_file_grouped_if #(parameter int VLEN = 128);
  localparam int NLANES = VLEN / 32;
  logic [4:0] readAddr1, readAddr2, readAddr3;
  logic [VLEN-1:0] readVector1, readVector2, readVector3, v0;
  logic cmd_valid, cmd_ready;
  logic [4:0] cmd_addr;
  logic [1:0] cmd_lmul;
  logic dat_valid, dat_ready;
  logic [VLEN-1:0] dat_vector;
  logic [NLANES-1:0] dat_lane_en;
  logic [31:0] busy;
  logic grp_done, cmd_err;
  modport master (
    output readAddr1, readAddr2, readAddr3, cmd_valid, cmd_addr, cmd_lmul,
           dat_valid, dat_vector, dat_lane_en,
    input  readVector1, readVector2, readVector3, v0, cmd_ready, dat_ready,
           busy, grp_done, cmd_err
  );
  modport slave (
    input  readAddr1, readAddr2, readAddr3, cmd_valid, cmd_addr, cmd_lmul,
           dat_valid, dat_vector, dat_lane_en,
    output readVector1, readVector2, readVector3, v0, cmd_ready, dat_ready,
           busy, grp_done, cmd_err
  );
endinterface

// File: rtl/vreg_file_grouped.sv
// vreg_file_grouped: 32 x VLEN vector register file with LMUL group writes and busy scoreboard
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of vreg_file_grouped_if (3 read ports + v0, cmd/dat handshake,
//           busy scoreboard, grp_done and cmd_err pulses)
module vreg_file_grouped #(
  parameter int VLEN = 128
) (
  input logic clk,
  input logic rst_n,
  vreg_file_grouped_if.slave bus
);
  localparam int NLANES = VLEN / 32;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [VLEN-1:0] vregs_q [32];
  logic [0:0] state_q, state_d;
  logic [4:0] base_q, base_d;
  logic [2:0] k_q, k_d, last_q, last_d;
  logic [31:0] busy_q, busy_d;
  logic done_q, done_d, err_q, err_d;
  logic cmd_fire, dat_fire, aligned, accept, last_beat;
  logic [3:0] grp_size;
  logic [4:0] wa;
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.dat_ready = state_q == BURST;
  assign bus.busy = busy_q;
  assign bus.grp_done = done_q;
  assign bus.cmd_err = err_q;
  assign bus.readVector1 = vregs_q[bus.readAddr1];
  assign bus.readVector2 = vregs_q[bus.readAddr2];
  assign bus.readVector3 = vregs_q[bus.readAddr3];
  assign bus.v0 = vregs_q[0];
  always_comb begin
    cmd_fire = bus.cmd_valid && bus.cmd_ready;
    dat_fire = bus.dat_valid && bus.dat_ready;
    grp_size = 4'd1 << bus.cmd_lmul;
    aligned = (bus.cmd_addr & 5'(grp_size - 4'd1)) == 5'd0;
    accept = cmd_fire && aligned;
    last_beat = k_q == last_q;
    wa = base_q + 5'(k_q);
    state_d = accept ? BURST : (dat_fire && last_beat) ? IDLE : state_q;
    base_d = accept ? bus.cmd_addr : base_q;
    last_d = accept ? 3'(grp_size - 4'd1) : last_q;
    k_d = accept ? 3'd0 : dat_fire ? k_q + 3'd1 : k_q;
    busy_d = accept ? busy_q | (((32'd1 << grp_size) - 32'd1) << bus.cmd_addr)
           : dat_fire ? busy_q & ~(32'd1 << wa) : busy_q;
    done_d = dat_fire && last_beat;
    err_d = cmd_fire && !aligned;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) vregs_q[r] <= '0;
      state_q <= IDLE;
      base_q <= '0;
      k_q <= '0;
      last_q <= '0;
      busy_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      k_q <= k_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      if (dat_fire)
        for (int i = 0; i < NLANES; i++)
          if (bus.dat_lane_en[i]) vregs_q[wa][32*i +: 32] <= bus.dat_vector[32*i +: 32];
    end
  end
endmodule
